// File: rtl/bomb_pkg.sv
// Shared types and constants for the time-bomb game sequencer.
package bomb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_LOCKOUT,
        S_DEFUSED,
        S_EXPLODED
    } state_e;

    // Codes shown on the spare 7-segment digit.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_LOCK  = 3'd2;
    localparam logic [2:0] ST_WON   = 3'd3;
    localparam logic [2:0] ST_BOOM  = 3'd4;

    localparam int DEF_MAX_ATTEMPTS = 3;
    localparam int DEF_LOCKOUT_S    = 2;
    localparam int DEF_A_W          = 4;
    localparam int DEF_B_W          = 3;

    function automatic logic [2:0] status_of(state_e s);
        case (s)
            S_ARMED, S_CHECK: status_of = ST_ARMED;
            S_LOCKOUT:        status_of = ST_LOCK;
            S_DEFUSED:        status_of = ST_WON;
            S_EXPLODED:       status_of = ST_BOOM;
            default:          status_of = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bomb_game_controller_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge detector: a one-cycle pulse three clocks after the input rises.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;
    logic pulse_q;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // which is what turns these four statements into a shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            meta_q     <= async_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            pulse_q    <= sync_q & ~sync_dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/bomb_game_controller.sv
// Game sequencer: arms the cronometer once the PIN is stored, checks defuse
// attempts, applies post-error lockout and decides between defused and exploded.
module bomb_game_controller
    import bomb_pkg::*;
#(
    parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
    parameter int LOCKOUT_S    = DEF_LOCKOUT_S,
    parameter int A_W          = DEF_A_W,
    parameter int B_W          = DEF_B_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick_1s,
    input  logic           config_done,
    input  logic [A_W-1:0] a_pin,
    input  logic [B_W-1:0] b_pin,
    input  logic [A_W-1:0] guess_a,
    input  logic [B_W-1:0] guess_b,
    input  logic           submit,
    input  logic           time_over,
    output logic           cron_start,
    output logic           game_won,
    output logic           exploded,
    output logic           lockout,
    output logic [2:0]     attempts_left,
    output logic [2:0]     status
);

    localparam logic [2:0] ATTEMPTS_INIT = 3'(MAX_ATTEMPTS);
    localparam logic [3:0] LOCKOUT_END   = 4'(LOCKOUT_S);

    state_e         state_q, state_d;
    logic [2:0]     attempts_q, attempts_d;
    logic [3:0]     lock_cnt_q, lock_cnt_d;
    logic [A_W-1:0] guess_a_q;
    logic [B_W-1:0] guess_b_q;

    logic           sub_p;
    logic           in_play;
    logic           pin_match;

    logic           cron_start_q;
    logic           game_won_q;
    logic           exploded_q;
    logic           lockout_q;
    logic [2:0]     status_q;

    sync_edge_detect u_submit_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (submit),
        .pulse_o (sub_p)
    );

    assign in_play   = (state_q == S_ARMED) || (state_q == S_CHECK) || (state_q == S_LOCKOUT);
    assign pin_match = ({guess_a_q, guess_b_q} == {a_pin, b_pin});

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        lock_cnt_d = lock_cnt_q;

        if (in_play && time_over) begin
            state_d = S_EXPLODED;
        end else if (in_play && !config_done) begin
            // PIN is being re-entered: start a fresh game once it is stored again.
            state_d    = S_IDLE;
            attempts_d = ATTEMPTS_INIT;
            lock_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (config_done) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (sub_p) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (pin_match) begin
                        state_d = S_DEFUSED;
                    end else begin
                        attempts_d = (attempts_q == 3'd0) ? 3'd0 : attempts_q - 3'd1;
                        if (attempts_d == 3'd0) begin
                            state_d = S_EXPLODED;
                        end else begin
                            state_d    = S_LOCKOUT;
                            lock_cnt_d = '0;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (tick_1s) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                        if (lock_cnt_d == LOCKOUT_END) state_d = S_ARMED;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters and outputs; outputs decode the next state so they line
    // up with the state register on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            attempts_q   <= ATTEMPTS_INIT;
            lock_cnt_q   <= '0;
            guess_a_q    <= '0;
            guess_b_q    <= '0;
            cron_start_q <= 1'b0;
            game_won_q   <= 1'b0;
            exploded_q   <= 1'b0;
            lockout_q    <= 1'b0;
            status_q     <= ST_IDLE;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            lock_cnt_q <= lock_cnt_d;
            if (sub_p) begin
                guess_a_q <= guess_a;
                guess_b_q <= guess_b;
            end
            cron_start_q <= state_d inside {S_ARMED, S_CHECK, S_LOCKOUT, S_DEFUSED};
            game_won_q   <= (state_d == S_DEFUSED);
            exploded_q   <= (state_d == S_EXPLODED);
            lockout_q    <= (state_d == S_LOCKOUT);
            status_q     <= status_of(state_d);
        end
    end

    assign cron_start    = cron_start_q;
    assign game_won      = game_won_q;
    assign exploded      = exploded_q;
    assign lockout       = lockout_q;
    assign attempts_left = attempts_q;
    assign status        = status_q;

endmodule
